// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle MIPS-subset control FSM.
// Optional macro BNE_EN adds the BNEEX state (encoding 12) for bne.
module mc_controller #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               iord,
  output logic               memwrite,
  output logic               irwrite,
  output logic               regdst,
  output logic               memtoreg,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [2:0]         alucontrol,
  output logic               pcen,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [STATE_W-1:0] {
    FETCH   = 0,
    DECODE  = 1,
    MEMADR  = 2,
    MEMRD   = 3,
    MEMWB   = 4,
    MEMWR   = 5,
    RTYPEEX = 6,
    RTYPEWB = 7,
    BEQEX   = 8,
    ADDIEX  = 9,
    ADDIWB  = 10,
    JEX     = 11,
    BNEEX   = 12
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BNE  = 6'b000101;

  state_t     state_q, state_d;
  logic       funct_bad;
  logic       funct_unk;
  logic [2:0] funct_alu;
  logic       pcwrite, branch;
  logic       memwrite_s, irwrite_s, regwrite_s;
`ifdef BNE_EN
  logic       bne;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FETCH;
      funct_bad <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == RTYPEEX) funct_bad <= funct_unk;
    end
  end

  always_comb begin
    funct_alu = 3'b010;
    funct_unk = 1'b0;
    case (funct)
      6'b100000: funct_alu = 3'b010;
      6'b100010: funct_alu = 3'b110;
      6'b100100: funct_alu = 3'b000;
      6'b100101: funct_alu = 3'b001;
      6'b101010: funct_alu = 3'b111;
      default:   funct_unk = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = FETCH;
    iord       = 1'b0;
    memwrite_s = 1'b0;
    irwrite_s  = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite_s = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucontrol = 3'b010;
    pcwrite    = 1'b0;
    branch     = 1'b0;
`ifdef BNE_EN
    bne        = 1'b0;
`endif
    case (state_q)
      FETCH: begin
        irwrite_s = 1'b1;
        pcwrite   = 1'b1;
        alusrcb   = 2'b01;
        state_d   = DECODE;
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYP:      state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JEX;
`ifdef BNE_EN
          OP_BNE:       state_d = BNEEX;
`endif
          default:      state_d = FETCH;
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord    = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_s = 1'b1;
      end
      MEMWR: begin
        iord       = 1'b1;
        memwrite_s = 1'b1;
      end
      RTYPEEX: begin
        alusrca    = 1'b1;
        alucontrol = funct_alu;
        state_d    = RTYPEWB;
      end
      RTYPEWB: begin
        regdst     = 1'b1;
        regwrite_s = ~funct_bad;
      end
      BEQEX: begin
        alusrca    = 1'b1;
        alucontrol = 3'b110;
        pcsrc      = 2'b01;
        branch     = 1'b1;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = ADDIWB;
      end
      ADDIWB: regwrite_s = 1'b1;
      JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
`ifdef BNE_EN
      BNEEX: begin
        alusrca    = 1'b1;
        alucontrol = 3'b110;
        pcsrc      = 2'b01;
        bne        = 1'b1;
      end
`endif
      default: state_d = FETCH;
    endcase
  end

  // Write enables are gated by reset so nothing commits while reset is low.
  assign memwrite = memwrite_s & reset;
  assign irwrite  = irwrite_s & reset;
  assign regwrite = regwrite_s & reset;
`ifdef BNE_EN
  assign pcen     = (pcwrite | (branch & zero) | (bne & ~zero)) & reset;
`else
  assign pcen     = (pcwrite | (branch & zero)) & reset;
`endif
  assign state    = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - table-driven bench for mc_controller.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  int applied = 0;
  int miscompares = 0;

  mc_controller #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
    .pcen(pcen), .state(state)
  );

  always #5 clk = ~clk;

  // {iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,pcsrc,alucontrol,pcen}
  localparam logic [14:0] O_RST   = 15'b0_0_0_0_0_0_0_01_00_010_0;
  localparam logic [14:0] O_FETCH = 15'b0_0_1_0_0_0_0_01_00_010_1;
  localparam logic [14:0] O_DEC   = 15'b0_0_0_0_0_0_0_11_00_010_0;
  localparam logic [14:0] O_MADR  = 15'b0_0_0_0_0_0_1_10_00_010_0;
  localparam logic [14:0] O_MRD   = 15'b1_0_0_0_0_0_0_00_00_010_0;
  localparam logic [14:0] O_MWB   = 15'b0_0_0_0_1_1_0_00_00_010_0;
  localparam logic [14:0] O_MWR   = 15'b1_1_0_0_0_0_0_00_00_010_0;
  localparam logic [14:0] O_RSUB  = 15'b0_0_0_0_0_0_1_00_00_110_0;
  localparam logic [14:0] O_RAND  = 15'b0_0_0_0_0_0_1_00_00_000_0;
  localparam logic [14:0] O_RBAD  = 15'b0_0_0_0_0_0_1_00_00_010_0;
  localparam logic [14:0] O_RWB   = 15'b0_0_0_1_0_1_0_00_00_010_0;
  localparam logic [14:0] O_RWBX  = 15'b0_0_0_1_0_0_0_00_00_010_0;
  localparam logic [14:0] O_BR_T  = 15'b0_0_0_0_0_0_1_00_01_110_1;
  localparam logic [14:0] O_BR_N  = 15'b0_0_0_0_0_0_1_00_01_110_0;
  localparam logic [14:0] O_AWB   = 15'b0_0_0_0_0_1_0_00_00_010_0;
  localparam logic [14:0] O_JEX   = 15'b0_0_0_0_0_0_0_00_10_010_1;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic [3:0]  exp_state;
    logic [14:0] exp_out;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic r, logic [5:0] o, logic [5:0] f, logic z,
                              logic [3:0] s, logic [14:0] e);
    vec_t v;
    v.rst = r; v.op = o; v.funct = f; v.zero = z; v.exp_state = s; v.exp_out = e;
    vecs.push_back(v);
  endfunction

  function automatic logic [14:0] outs();
    return {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
            alusrcb, pcsrc, alucontrol, pcen};
  endfunction

  task automatic check(string name, logic [3:0] es, logic [14:0] eo);
    applied++;
    if (state !== es) begin
      miscompares++;
      $display("FAIL %s state: got %0d expected %0d", name, state, es);
    end
    applied++;
    if (outs() !== eo) begin
      miscompares++;
      $display("FAIL %s outputs: got %b expected %b", name, outs(), eo);
    end
  endtask

  task automatic run_to(logic [5:0] o, logic [3:0] target);
    int n = 0;
    op = o;
    while (state !== target && n < 10) begin
      @(posedge clk); #1; n++;
    end
    applied++;
    if (state !== target) begin
      miscompares++;
      $display("FAIL run_to state: got %0d expected %0d", state, target);
    end
  endtask

  initial begin
    reset = 1'b0; op = 6'b0; funct = 6'b0; zero = 1'b0;

    for (int i = 0; i < 3; i++) add(0, 6'b100011, 6'b0, 0, 0, O_RST);
    // lw
    add(1, 6'b100011, 6'b0, 0, 0, O_FETCH);
    add(1, 6'b100011, 6'b0, 0, 1, O_DEC);
    add(1, 6'b100011, 6'b0, 0, 2, O_MADR);
    add(1, 6'b100011, 6'b0, 0, 3, O_MRD);
    add(1, 6'b100011, 6'b0, 0, 4, O_MWB);
    // sw
    add(1, 6'b101011, 6'b0, 0, 0, O_FETCH);
    add(1, 6'b101011, 6'b0, 0, 1, O_DEC);
    add(1, 6'b101011, 6'b0, 0, 2, O_MADR);
    add(1, 6'b101011, 6'b0, 0, 5, O_MWR);
    // R-type sub, unknown funct, then and (funct_bad must clear)
    add(1, 6'b000000, 6'b100010, 0, 0, O_FETCH);
    add(1, 6'b000000, 6'b100010, 0, 1, O_DEC);
    add(1, 6'b000000, 6'b100010, 0, 6, O_RSUB);
    add(1, 6'b000000, 6'b100010, 0, 7, O_RWB);
    add(1, 6'b000000, 6'b111111, 0, 0, O_FETCH);
    add(1, 6'b000000, 6'b111111, 0, 1, O_DEC);
    add(1, 6'b000000, 6'b111111, 0, 6, O_RBAD);
    add(1, 6'b000000, 6'b111111, 0, 7, O_RWBX);
    add(1, 6'b000000, 6'b100100, 0, 0, O_FETCH);
    add(1, 6'b000000, 6'b100100, 0, 1, O_DEC);
    add(1, 6'b000000, 6'b100100, 0, 6, O_RAND);
    add(1, 6'b000000, 6'b100100, 0, 7, O_RWB);
    // beq taken / not taken
    add(1, 6'b000100, 6'b0, 1, 0, O_FETCH);
    add(1, 6'b000100, 6'b0, 1, 1, O_DEC);
    add(1, 6'b000100, 6'b0, 1, 8, O_BR_T);
    add(1, 6'b000100, 6'b0, 0, 0, O_FETCH);
    add(1, 6'b000100, 6'b0, 0, 1, O_DEC);
    add(1, 6'b000100, 6'b0, 0, 8, O_BR_N);
    // addi
    add(1, 6'b001000, 6'b0, 0, 0, O_FETCH);
    add(1, 6'b001000, 6'b0, 0, 1, O_DEC);
    add(1, 6'b001000, 6'b0, 0, 9, O_MADR);
    add(1, 6'b001000, 6'b0, 0, 10, O_AWB);
    // j
    add(1, 6'b000010, 6'b0, 0, 0, O_FETCH);
    add(1, 6'b000010, 6'b0, 0, 1, O_DEC);
    add(1, 6'b000010, 6'b0, 0, 11, O_JEX);
    // illegal opcode
    add(1, 6'b111111, 6'b0, 0, 0, O_FETCH);
    add(1, 6'b111111, 6'b0, 0, 1, O_DEC);
    // bne
    add(1, 6'b000101, 6'b0, 0, 0, O_FETCH);
    add(1, 6'b000101, 6'b0, 0, 1, O_DEC);
`ifdef BNE_EN
    add(1, 6'b000101, 6'b0, 0, 12, O_BR_T);
    add(1, 6'b000101, 6'b0, 1, 0, O_FETCH);
    add(1, 6'b000101, 6'b0, 1, 1, O_DEC);
    add(1, 6'b000101, 6'b0, 1, 12, O_BR_N);
`endif
    add(1, 6'b000000, 6'b0, 0, 0, O_FETCH);

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      reset = vecs[i].rst; op = vecs[i].op; funct = vecs[i].funct; zero = vecs[i].zero;
      @(negedge clk);
      check($sformatf("vec%0d", i), vecs[i].exp_state, vecs[i].exp_out);
    end

    // reset dropped mid-lw in MEMRD aborts to FETCH without a clock edge
    @(posedge clk); #1;
    funct = 6'b0; zero = 1'b0;
    run_to(6'b100011, 4'd3);
    #2 reset = 1'b0; #1;
    check("lw_abort", 4'd0, O_RST);
    @(posedge clk); #1;
    check("lw_abort_hold", 4'd0, O_RST);
    reset = 1'b1; #1;
    check("lw_abort_release", 4'd0, O_FETCH);

    // reset dropped while sw is in MEMWR: memwrite must fall at once
    run_to(6'b101011, 4'd5);
    applied++;
    if (memwrite !== 1'b1) begin
      miscompares++;
      $display("FAIL sw_memwr memwrite: got %b expected 1", memwrite);
    end
    #2 reset = 1'b0; #1;
    check("sw_abort", 4'd0, O_RST);

    // reset dropped in MEMWB must suppress regwrite
    @(posedge clk); #1; reset = 1'b1;
    run_to(6'b100011, 4'd4);
    #2 reset = 1'b0; #1;
    check("memwb_abort", 4'd0, O_RST);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
